uop_retire_merger: RTL and testbench



---
 rtl/uop_retire_pkg.sv | 40 ++++
 rtl/uop_retire_merger_fifo.sv | 54 +++++
 rtl/uop_retire_merger.sv | 151 +++++++++++++++
 tb/tb_uop_retire_merger.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_retire_pkg.sv
// Shared types for the micro-op retire merger.
// Event layout, FSM states and field widths.
package uop_retire_pkg;

  localparam int UOP_CNT_W = 6;
  localparam int UOP_IDX_W = 5;
  localparam int PC_W      = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    GATHER = 1'b1
  } state_t;

  typedef struct packed {
    logic [UOP_CNT_W-1:0] uops;
    logic                 exc;
    logic [UOP_IDX_W-1:0] exc_idx;
    logic                 err;
  } ret_meta_t;

  typedef struct packed {
    logic [0:PC_W-1] pc;
    ret_meta_t       meta;
  } ret_event_t;

  function automatic ret_meta_t mk_meta(
    input logic [UOP_CNT_W-1:0] uops,
    input logic                 exc,
    input logic [UOP_IDX_W-1:0] idx,
    input logic                 err
  );
    ret_meta_t m;
    m.uops    = uops;
    m.exc     = exc;
    m.exc_idx = idx;
    m.err     = err;
    return m;
  endfunction

endpackage

// File: rtl/uop_retire_merger_fifo.sv
// Retire event buffer: two pushes and one pop per cycle.
// push0 lands before push1 when both fire.
module retire_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push0,
  input  logic [W-1:0] din0,
  input  logic         push1,
  input  logic [W-1:0] din1,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [AW:0]  free
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW-1:0] wr1;
  logic          do_pop;

  assign do_pop = pop && (cnt != '0);
  assign wr1    = wr_ptr + AW'(push0);
  assign valid  = (cnt != '0);
  assign dout   = mem[rd_ptr];
  assign free   = (AW+1)'(DEPTH) - cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push0) mem[wr_ptr] <= din0;
      if (push1) mem[wr1] <= din1;
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push0) + (AW+1)'(push1)
           - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uop_retire_merger.sv
// Merges completed micro-ops sharing a PC into one
// architectural retire event, buffered for commit.
module uop_retire_merger
  import uop_retire_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int MAX_UOPS   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [0:PC_WIDTH-1]  wb_pc,
  input  logic                 wb_last,
  input  logic                 wb_exc,
  output logic                 ret_valid,
  input  logic                 ret_ready,
  output logic [0:PC_WIDTH-1]  ret_pc,
  output logic [5:0]           ret_uops,
  output logic                 ret_exc,
  output logic [4:0]           ret_exc_idx,
  output logic                 ret_err,
  output logic                 busy
);

  localparam int MW  = $bits(ret_meta_t);
  localparam int EW  = PC_WIDTH + MW;
  localparam int FAW = $clog2(FIFO_DEPTH);

  state_t               state, state_n;
  logic [0:PC_WIDTH-1]  grp_pc, grp_pc_n;
  logic [UOP_CNT_W-1:0] grp_cnt, grp_cnt_n;
  logic                 grp_exc, grp_exc_n;
  logic [UOP_IDX_W-1:0] grp_idx, grp_idx_n;

  logic                 push0, push1;
  logic [EW-1:0]        din0, din1;
  logic [EW-1:0]        head;
  logic [FAW:0]         free;
  ret_meta_t            head_meta;

  logic                 accept;
  logic                 same;
  logic                 full;
  logic [UOP_CNT_W-1:0] cnt_inc;
  logic [UOP_IDX_W-1:0] new_idx;
  logic [EW-1:0]        one_ev;

  assign wb_ready = (free >= (FAW+1)'(2));
  assign accept   = wb_valid && wb_ready && !flush;
  assign same     = (wb_pc == grp_pc);
  assign full     = (grp_cnt == UOP_CNT_W'(MAX_UOPS));
  assign cnt_inc  = grp_cnt + UOP_CNT_W'(1);
  assign new_idx  = (!grp_exc && wb_exc)
                  ? grp_cnt[UOP_IDX_W-1:0] : grp_idx;
  assign one_ev   = {wb_pc, mk_meta(6'd1, wb_exc, 5'd0, 1'b0)};

  always_comb begin
    state_n   = state;
    grp_pc_n  = grp_pc;
    grp_cnt_n = grp_cnt;
    grp_exc_n = grp_exc;
    grp_idx_n = grp_idx;
    push0     = 1'b0;
    push1     = 1'b0;
    din0      = one_ev;
    din1      = one_ev;
    if (accept) begin
      unique case (1'b1)
        (state == IDLE): begin
          grp_pc_n  = wb_pc;
          grp_cnt_n = UOP_CNT_W'(1);
          grp_exc_n = wb_exc;
          grp_idx_n = '0;
          if (wb_last) push0 = 1'b1;
          else state_n = GATHER;
        end
        (state == GATHER && same && !full): begin
          grp_cnt_n = cnt_inc;
          grp_exc_n = grp_exc || wb_exc;
          grp_idx_n = new_idx;
          if (wb_last) begin
            push0   = 1'b1;
            din0    = {grp_pc, mk_meta(cnt_inc,
                        grp_exc || wb_exc, new_idx, 1'b0)};
            state_n = IDLE;
          end
        end
        (state == GATHER && !(same && !full)): begin
          // Close the broken group, then restart from this op
          push0     = 1'b1;
          din0      = {grp_pc, mk_meta(grp_cnt, grp_exc,
                        grp_idx, 1'b1)};
          grp_pc_n  = wb_pc;
          grp_cnt_n = UOP_CNT_W'(1);
          grp_exc_n = wb_exc;
          grp_idx_n = '0;
          if (wb_last) begin
            push1   = 1'b1;
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state   <= IDLE;
      grp_pc  <= '0;
      grp_cnt <= '0;
      grp_exc <= 1'b0;
      grp_idx <= '0;
    end else begin
      state   <= state_n;
      grp_pc  <= grp_pc_n;
      grp_cnt <= grp_cnt_n;
      grp_exc <= grp_exc_n;
      grp_idx <= grp_idx_n;
    end
  end

  retire_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push0 (push0),
    .din0  (din0),
    .push1 (push1),
    .din1  (din1),
    .pop   (ret_valid && ret_ready),
    .dout  (head),
    .valid (ret_valid),
    .free  (free)
  );

  assign ret_pc      = head[EW-1 -: PC_WIDTH];
  assign head_meta   = head[MW-1:0];
  assign ret_uops    = head_meta.uops;
  assign ret_exc     = head_meta.exc;
  assign ret_exc_idx = head_meta.exc_idx;
  assign ret_err     = head_meta.err;
  assign busy        = (state == GATHER);

endmodule

// File: tb/tb_uop_retire_merger.sv
// Scoreboard bench for uop_retire_merger: directed
// scenarios followed by randomized micro-op streams.
module tb_uop_retire_merger;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        wb_valid, wb_ready, wb_last, wb_exc;
  logic [31:0] wb_pc;
  logic        ret_valid, ret_ready;
  logic [31:0] ret_pc;
  logic [5:0]  ret_uops;
  logic        ret_exc;
  logic [4:0]  ret_exc_idx;
  logic        ret_err;
  logic        busy;

  always #5 clk = ~clk;

  uop_retire_merger #(
    .PC_WIDTH   (32),
    .MAX_UOPS   (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_pc       (wb_pc),
    .wb_last     (wb_last),
    .wb_exc      (wb_exc),
    .ret_valid   (ret_valid),
    .ret_ready   (ret_ready),
    .ret_pc      (ret_pc),
    .ret_uops    (ret_uops),
    .ret_exc     (ret_exc),
    .ret_exc_idx (ret_exc_idx),
    .ret_err     (ret_err),
    .busy        (busy)
  );

  typedef struct {
    logic [31:0] pc;
    int          uops;
    bit          exc;
    int          idx;
    bit          err;
  } ev_t;

  ev_t         exp_q[$];
  bit          cur_exc[$];
  logic [31:0] cur_pc;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rr_rand = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference: an architectural instruction is the run of ops
  // sharing a PC, capped at 32, ended by last.
  function automatic void emit(input bit err);
    ev_t e;
    e.pc   = cur_pc;
    e.uops = cur_exc.size();
    e.exc  = 1'b0;
    e.idx  = 0;
    e.err  = err;
    for (int i = cur_exc.size() - 1; i >= 0; i--)
      if (cur_exc[i]) begin
        e.exc = 1'b1;
        e.idx = i;
      end
    exp_q.push_back(e);
    cur_exc.delete();
  endfunction

  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
      cur_exc.delete();
    end else if (wb_valid && wb_ready) begin
      if (cur_exc.size() != 0 &&
          (wb_pc != cur_pc || cur_exc.size() == 32))
        emit(1'b1);
      cur_pc = wb_pc;
      cur_exc.push_back(wb_exc);
      if (wb_last) emit(1'b0);
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (!rst && !flush && ret_valid && ret_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_event: got pc=%0h uops=%0d, none expected",
                 ret_pc, ret_uops);
      end else begin
        e = exp_q.pop_front();
        if ({ret_pc, ret_uops, ret_exc, ret_exc_idx, ret_err} !==
            {e.pc, 6'(e.uops), e.exc, 5'(e.idx), e.err}) begin
          n_bad++;
          $display("FAIL event: got pc=%0h uops=%0d exc=%0d idx=%0d err=%0d expected pc=%0h uops=%0d exc=%0d idx=%0d err=%0d",
                   ret_pc, ret_uops, ret_exc, ret_exc_idx, ret_err,
                   e.pc, e.uops, e.exc, e.idx, e.err);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr_rand) ret_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] pc,
                      input bit last, input bit exc);
    int t = 0;
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_last  = last;
    wb_exc   = exc;
    while (!wb_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (!wb_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got wb_ready=0 expected 1 (pc=%0h)", pc);
    end else begin
      tick(1);
    end
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    ret_ready = 1'b1;
    while ((exp_q.size() != 0 || ret_valid) && t < 500) begin
      tick(1);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int len, r;
    bit last;
    logic [31:0] pc;
    rst       = 1'b1;
    flush     = 1'b0;
    wb_valid  = 1'b0;
    wb_pc     = '0;
    wb_last   = 1'b0;
    wb_exc    = 1'b0;
    ret_ready = 1'b0;
    tick(3);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_pc", ret_pc, 0);
    chk("rst_ret_uops", ret_uops, 0);
    chk("rst_ret_exc", ret_exc, 0);
    chk("rst_ret_exc_idx", ret_exc_idx, 0);
    chk("rst_ret_err", ret_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_ready", wb_ready, 1);
    rst = 1'b0;
    tick(1);

    send(32'h100, 1, 0);
    chk("single_latency", ret_valid, 1);
    chk("single_uops", ret_uops, 1);
    chk("single_pc", ret_pc, 32'h100);
    ret_ready = 1'b1;
    tick(2);

    send(32'h104, 0, 0);
    chk("pair_busy_high", busy, 1);
    send(32'h104, 1, 0);
    chk("pair_busy_low", busy, 0);
    tick(3);

    for (int i = 0; i < 32; i++) send(32'h400, i == 31, i == 5);
    for (int i = 0; i < 33; i++) send(32'h500, 0, 0);
    chk("overflow_busy", busy, 1);
    send(32'h500, 1, 1);
    drain();

    ret_ready = 1'b0;
    send(32'h200, 0, 0);
    send(32'h204, 1, 0);
    chk("pcchg_head_pc", ret_pc, 32'h200);
    chk("pcchg_head_err", ret_err, 1);
    chk("pcchg_wb_ready", wb_ready, 1);
    drain();

    ret_ready = 1'b0;
    send(32'h10, 1, 0);
    send(32'h14, 1, 0);
    send(32'h18, 1, 0);
    chk("bp_wb_ready_low", wb_ready, 0);
    ret_ready = 1'b1;
    tick(1);
    chk("bp_wb_ready_high", wb_ready, 1);
    drain();

    ret_ready = 1'b0;
    send(32'h600, 1, 0);
    send(32'h700, 0, 0);
    send(32'h700, 0, 0);
    chk("flush_pre_busy", busy, 1);
    wb_valid = 1'b1;
    wb_pc    = 32'h300;
    wb_last  = 1'b1;
    wb_exc   = 1'b0;
    flush    = 1'b1;
    tick(1);
    flush    = 1'b0;
    wb_valid = 1'b0;
    chk("flush_ret_valid", ret_valid, 0);
    chk("flush_busy", busy, 0);
    ret_ready = 1'b1;
    tick(5);
    chk("flush_no_event", ret_valid, 0);

    rr_rand = 1'b1;
    for (int g = 0; g < 400; g++) begin
      pc = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      r  = $urandom_range(0, 9);
      if (r < 5) len = $urandom_range(1, 2);
      else if (r < 8) len = $urandom_range(3, 8);
      else len = $urandom_range(28, 36);
      for (int i = 0; i < len; i++) begin
        last = (i == len - 1) && ($urandom_range(0, 9) != 0);
        send(pc, last, $urandom_range(0, 15) == 0);
        if ($urandom_range(0, 5) == 0) tick(1);
      end
      if ($urandom_range(0, 49) == 0) begin
        wb_valid = $urandom_range(0, 1);
        wb_pc    = 32'h300;
        wb_last  = 1'b1;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        wb_valid = 1'b0;
      end
    end
    rr_rand = 1'b0;
    tick(2);
    drain();
    chk("final_ret_valid", ret_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
